io_stage: RTL

IO_STAGE -- requirements
Module: io_stage

---
 rtl/io_stage.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/io_stage.sv
// Memory-response stage: waits for the data RAM reply of a load, aligns and extends it,
// and hands the instruction to wb while dropping replies that belong to flushed instructions.

package cpu_core_params;
    typedef logic [31:0] cpu_data_t;
    typedef logic [31:0] program_count_t;
    typedef logic [4:0]  register_address_t;
    typedef logic [3:0]  write_strobe_t;
endpackage

package ex_stage_params;
    typedef enum logic [1:0] {
        LOAD_NONE = 2'd0,
        LOAD_BYTE = 2'd1,
        LOAD_HALF = 2'd2,
        LOAD_WORD = 2'd3
    } load_type_t;

    typedef struct packed {
        logic                                valid;
        cpu_core_params::program_count_t     program_count;
        cpu_core_params::cpu_data_t          final_result;
        logic                                register_file_write_enabled;
        cpu_core_params::register_address_t  register_file_write_address;
        cpu_core_params::write_strobe_t      register_file_write_strobe;
        load_type_t                          load_type;
        logic                                load_unsigned;
        logic [1:0]                          address_low;
        logic                                request_issued;
        logic                                exception_valid;
        logic [4:0]                          exception_code;
        logic                                is_delay_slot;
        cpu_core_params::cpu_data_t          bad_virtual_address;
        logic                                eret_flush;
        logic                                cp0_write_enabled;
        logic [7:0]                          cp0_address;
        logic                                tlb_probe;
        logic                                tlb_read;
        logic                                tlb_write_indexed;
    } ex_to_io_bus_t;
endpackage

package io_stage_params;
    typedef struct packed {
        cpu_core_params::program_count_t     program_count;
        cpu_core_params::cpu_data_t          final_result;
        logic                                register_file_write_enabled;
        cpu_core_params::register_address_t  register_file_write_address;
        cpu_core_params::write_strobe_t      register_file_write_strobe;
        ex_stage_params::load_type_t         load_type;
        logic                                load_unsigned;
        logic [1:0]                          address_low;
        logic                                exception_valid;
        logic [4:0]                          exception_code;
        logic                                is_delay_slot;
        cpu_core_params::cpu_data_t          bad_virtual_address;
        logic                                eret_flush;
        logic                                cp0_write_enabled;
        logic [7:0]                          cp0_address;
        logic                                tlb_probe;
        logic                                tlb_read;
        logic                                tlb_write_indexed;
    } io_payload_t;

    typedef struct packed {
        logic                                valid;
        cpu_core_params::program_count_t     program_count;
        cpu_core_params::cpu_data_t          final_result;
        logic                                register_file_write_enabled;
        cpu_core_params::register_address_t  register_file_write_address;
        cpu_core_params::write_strobe_t      register_file_write_strobe;
        logic                                exception_valid;
        logic [4:0]                          exception_code;
        logic                                is_delay_slot;
        cpu_core_params::cpu_data_t          bad_virtual_address;
        logic                                eret_flush;
        logic                                cp0_write_enabled;
        logic [7:0]                          cp0_address;
        logic                                tlb_probe;
        logic                                tlb_read;
        logic                                tlb_write_indexed;
    } io_to_wb_bus_t;

    typedef struct packed {
        logic                                valid;
        logic                                blocked;
        cpu_core_params::register_address_t  write_register;
        cpu_core_params::write_strobe_t      write_strobe;
        cpu_core_params::cpu_data_t          write_data;
    } io_to_id_back_pass_bus_t;
endpackage

module io_stage (
    input  logic                                     clock,
    input  logic                                     reset,
    input  ex_stage_params::ex_to_io_bus_t           ex_to_io_bus,
    output logic                                     io_allow_in,
    input  logic                                     wb_allow_in,
    output io_stage_params::io_to_wb_bus_t           io_to_wb_bus,
    output io_stage_params::io_to_id_back_pass_bus_t io_to_id_back_pass_bus,
    input  logic                                     data_ram_data_ok,
    input  logic [31:0]                              data_ram_read_data,
    input  logic                                     wb_have_exception_forwards,
    output logic                                     io_have_exception_forwards
);
    import ex_stage_params::*;

    logic                         io_valid_q, io_valid_d;
    logic                         wait_response_q, wait_response_d;
    logic                         buffer_valid_q, buffer_valid_d;
    cpu_core_params::cpu_data_t   buffer_q, buffer_d;
    logic [1:0]                   discard_count_q, discard_count_d;
    io_stage_params::io_payload_t payload_q, payload_d;

    logic                         io_ready_go;
    logic                         response_for_io;
    logic                         response_hit;
    logic                         capture;
    logic                         leave;
    logic                         flush;
    logic                         discard_inc;
    logic                         discard_dec;
    cpu_core_params::cpu_data_t   raw_word;
    cpu_core_params::cpu_data_t   aligned_result;
    logic [7:0]                   load_byte;
    logic [15:0]                  load_half;

    assign flush           = wb_have_exception_forwards;
    assign response_for_io = data_ram_data_ok && (discard_count_q == 2'd0);
    assign response_hit    = io_valid_q && wait_response_q && response_for_io;
    assign io_ready_go     = !wait_response_q || buffer_valid_q || response_for_io
                             || payload_q.exception_valid || payload_q.eret_flush;
    assign io_allow_in     = !io_valid_q || (io_ready_go && wb_allow_in);
    assign capture         = io_allow_in && ex_to_io_bus.valid;
    assign leave           = io_valid_q && io_ready_go && wb_allow_in;

    // A pending reply of a flushed instruction must be swallowed later, unless it arrives right now.
    assign discard_inc     = flush && io_valid_q && wait_response_q && !response_hit;
    assign discard_dec     = data_ram_data_ok && (discard_count_q != 2'd0);

    always_comb begin
        io_valid_d      = io_valid_q;
        wait_response_d = wait_response_q;
        buffer_valid_d  = buffer_valid_q;
        buffer_d        = buffer_q;
        discard_count_d = discard_count_q;
        payload_d       = payload_q;

        if (io_allow_in) begin
            io_valid_d = ex_to_io_bus.valid;
        end
        if (response_hit) begin
            wait_response_d = 1'b0;
        end
        if (io_allow_in) begin
            wait_response_d = capture && ex_to_io_bus.request_issued
                              && !ex_to_io_bus.exception_valid && !ex_to_io_bus.eret_flush;
        end
        if (response_hit && !wb_allow_in) begin
            buffer_valid_d = 1'b1;
            buffer_d       = data_ram_read_data;
        end
        if (leave) begin
            buffer_valid_d = 1'b0;
        end
        if (flush) begin
            io_valid_d      = 1'b0;
            wait_response_d = 1'b0;
            buffer_valid_d  = 1'b0;
        end

        if (discard_inc && !discard_dec && discard_count_q != 2'd3) begin
            discard_count_d = discard_count_q + 2'd1;
        end else if (discard_dec && !discard_inc) begin
            discard_count_d = discard_count_q - 2'd1;
        end

        if (capture) begin
            payload_d.program_count               = ex_to_io_bus.program_count;
            payload_d.final_result                = ex_to_io_bus.final_result;
            payload_d.register_file_write_enabled = ex_to_io_bus.register_file_write_enabled;
            payload_d.register_file_write_address = ex_to_io_bus.register_file_write_address;
            payload_d.register_file_write_strobe  = ex_to_io_bus.register_file_write_strobe;
            payload_d.load_type                   = ex_to_io_bus.load_type;
            payload_d.load_unsigned               = ex_to_io_bus.load_unsigned;
            payload_d.address_low                 = ex_to_io_bus.address_low;
            payload_d.exception_valid             = ex_to_io_bus.exception_valid;
            payload_d.exception_code              = ex_to_io_bus.exception_code;
            payload_d.is_delay_slot               = ex_to_io_bus.is_delay_slot;
            payload_d.bad_virtual_address         = ex_to_io_bus.bad_virtual_address;
            payload_d.eret_flush                  = ex_to_io_bus.eret_flush;
            payload_d.cp0_write_enabled           = ex_to_io_bus.cp0_write_enabled;
            payload_d.cp0_address                 = ex_to_io_bus.cp0_address;
            payload_d.tlb_probe                   = ex_to_io_bus.tlb_probe;
            payload_d.tlb_read                    = ex_to_io_bus.tlb_read;
            payload_d.tlb_write_indexed           = ex_to_io_bus.tlb_write_indexed;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            io_valid_q      <= 1'b0;
            wait_response_q <= 1'b0;
            buffer_valid_q  <= 1'b0;
            discard_count_q <= 2'd0;
        end else begin
            io_valid_q      <= io_valid_d;
            wait_response_q <= wait_response_d;
            buffer_valid_q  <= buffer_valid_d;
            discard_count_q <= discard_count_d;
        end
    end

    always_ff @(posedge clock) begin
        buffer_q  <= buffer_d;
        payload_q <= payload_d;
    end

    always_comb begin
        raw_word = buffer_valid_q ? buffer_q : data_ram_read_data;
        case (payload_q.address_low)
            2'd1:    load_byte = raw_word[15:8];
            2'd2:    load_byte = raw_word[23:16];
            2'd3:    load_byte = raw_word[31:24];
            default: load_byte = raw_word[7:0];
        endcase
        load_half = payload_q.address_low[1] ? raw_word[31:16] : raw_word[15:0];
        case (payload_q.load_type)
            LOAD_BYTE: aligned_result = {{24{!payload_q.load_unsigned && load_byte[7]}}, load_byte};
            LOAD_HALF: aligned_result = {{16{!payload_q.load_unsigned && load_half[15]}}, load_half};
            LOAD_WORD: aligned_result = raw_word;
            default:   aligned_result = payload_q.final_result;
        endcase
    end

    always_comb begin
        io_to_wb_bus.valid                       = io_valid_q && io_ready_go;
        io_to_wb_bus.program_count               = payload_q.program_count;
        io_to_wb_bus.final_result                = aligned_result;
        io_to_wb_bus.register_file_write_enabled = payload_q.register_file_write_enabled;
        io_to_wb_bus.register_file_write_address = payload_q.register_file_write_address;
        io_to_wb_bus.register_file_write_strobe  = payload_q.register_file_write_strobe;
        io_to_wb_bus.exception_valid             = payload_q.exception_valid;
        io_to_wb_bus.exception_code              = payload_q.exception_code;
        io_to_wb_bus.is_delay_slot               = payload_q.is_delay_slot;
        io_to_wb_bus.bad_virtual_address         = payload_q.bad_virtual_address;
        io_to_wb_bus.eret_flush                  = payload_q.eret_flush;
        io_to_wb_bus.cp0_write_enabled           = payload_q.cp0_write_enabled;
        io_to_wb_bus.cp0_address                 = payload_q.cp0_address;
        io_to_wb_bus.tlb_probe                   = payload_q.tlb_probe;
        io_to_wb_bus.tlb_read                    = payload_q.tlb_read;
        io_to_wb_bus.tlb_write_indexed           = payload_q.tlb_write_indexed;

        io_to_id_back_pass_bus.valid          = io_valid_q && payload_q.register_file_write_enabled;
        io_to_id_back_pass_bus.blocked        = io_to_id_back_pass_bus.valid
                                                && (payload_q.load_type != LOAD_NONE) && !io_ready_go;
        io_to_id_back_pass_bus.write_register = payload_q.register_file_write_address;
        io_to_id_back_pass_bus.write_strobe   = payload_q.register_file_write_strobe;
        io_to_id_back_pass_bus.write_data     = aligned_result;

        io_have_exception_forwards = io_valid_q && (payload_q.exception_valid || payload_q.eret_flush);
    end

    // Three outstanding stale replies cannot happen in a correct pipeline.
    discard_not_saturated: assert property (@(posedge clock) disable iff (reset) discard_count_q != 2'd3);

endmodule
